// File: rtl/tge_tx_arbiter.sv
// Round-robin TX arbiter between the application stream and CPU TX buffer.
// Frames are never preempted; an inter-frame gap follows every frame.
module tge_tx_arbiter #(
    parameter int IFG_CYCLES = 2
) (
    input  logic        mac_clk,
    input  logic        mac_rst,
    input  logic [63:0] app_data,
    input  logic        app_valid,
    input  logic        app_eof,
    output logic        app_ready,
    input  logic        cpu_tx_ready,
    input  logic [7:0]  cpu_tx_size,
    output logic [7:0]  cpu_tx_buffer_addr,
    input  logic [63:0] cpu_tx_buffer_rd_data,
    output logic        cpu_tx_done,
    output logic [63:0] mac_tx_data,
    output logic        mac_tx_valid,
    output logic        mac_tx_eof,
    input  logic        mac_tx_ready,
    output logic [15:0] cpu_frames_sent
);

    typedef enum logic [2:0] {
        IDLE,
        APP,
        CPU_READ,
        CPU_SEND,
        GAP
    } state_t;

    localparam int GW = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;
    localparam logic [GW-1:0] GAP_LAST =
        GW'((IFG_CYCLES > 0) ? IFG_CYCLES - 1 : 0);
    localparam state_t POST = (IFG_CYCLES > 0) ? GAP : IDLE;

    state_t        state;
    logic          last_cpu;
    logic          armed;
    logic [7:0]    size_q;
    logic [7:0]    addr_q;
    logic          done_q;
    logic [15:0]   frames_q;
    logic [GW-1:0] gap_cnt;

    logic cpu_pend;
    logic grant_cpu;
    logic grant_app;
    logic app_acc;
    logic cpu_acc;
    logic cpu_last;

    // armed blocks a held-high cpu_tx_ready from resending a finished frame
    assign cpu_pend  = cpu_tx_ready && armed;
    assign grant_cpu = cpu_pend && (!app_valid || !last_cpu);
    assign grant_app = app_valid && !grant_cpu;
    assign app_acc   = (state == APP) && app_valid && mac_tx_ready;
    assign cpu_acc   = (state == CPU_SEND) && mac_tx_ready;
    assign cpu_last  = (addr_q == size_q - 8'd1);

    assign cpu_tx_buffer_addr = addr_q;
    assign cpu_tx_done        = done_q;
    assign cpu_frames_sent    = frames_q;

    always_comb begin
        mac_tx_data  = '0;
        mac_tx_valid = 1'b0;
        mac_tx_eof   = 1'b0;
        app_ready    = 1'b0;
        unique case (state)
            APP: begin
                mac_tx_data  = app_data;
                mac_tx_valid = app_valid;
                mac_tx_eof   = app_eof;
                app_ready    = mac_tx_ready;
            end
            CPU_SEND: begin
                mac_tx_data  = cpu_tx_buffer_rd_data;
                mac_tx_valid = 1'b1;
                mac_tx_eof   = cpu_last;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge mac_clk or posedge mac_rst) begin
        if (mac_rst) begin
            state    <= IDLE;
            last_cpu <= 1'b1;
            armed    <= 1'b1;
            size_q   <= '0;
            addr_q   <= '0;
            done_q   <= 1'b0;
            frames_q <= '0;
            gap_cnt  <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (grant_app) begin
                        state    <= APP;
                        last_cpu <= 1'b0;
                    end else if (grant_cpu) begin
                        if (cpu_tx_size == 8'd0) begin
                            done_q   <= 1'b1;
                            armed    <= 1'b0;
                            last_cpu <= 1'b1;
                        end else begin
                            size_q <= cpu_tx_size;
                            addr_q <= '0;
                            state  <= CPU_READ;
                        end
                    end
                end
                APP: begin
                    if (app_acc && app_eof) begin
                        state   <= POST;
                        gap_cnt <= '0;
                    end
                end
                CPU_READ: begin
                    state <= CPU_SEND;
                end
                CPU_SEND: begin
                    if (cpu_acc) begin
                        if (cpu_last) begin
                            addr_q   <= '0;
                            done_q   <= 1'b1;
                            frames_q <= frames_q + 16'd1;
                            armed    <= 1'b0;
                            last_cpu <= 1'b1;
                            state    <= POST;
                            gap_cnt  <= '0;
                        end else begin
                            addr_q <= addr_q + 8'd1;
                            state  <= CPU_READ;
                        end
                    end
                end
                GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        state   <= IDLE;
                        gap_cnt <= '0;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
            // a low cpu_tx_ready always re-arms, even on a completion cycle
            if (!cpu_tx_ready) armed <= 1'b1;
        end
    end

endmodule

// File: tb/tb_tge_tx_arbiter.sv
// Directed bench for tge_tx_arbiter: CPU frames, app frames, arbitration,
// back-pressure, re-arming, zero-size frames and mid-frame reset.
module tb_tge_tx_arbiter;

    logic        mac_clk = 1'b0;
    logic        mac_rst;
    logic [63:0] app_data;
    logic        app_valid;
    logic        app_eof;
    logic        app_ready;
    logic        cpu_tx_ready;
    logic [7:0]  cpu_tx_size;
    logic [7:0]  cpu_tx_buffer_addr;
    logic [63:0] cpu_tx_buffer_rd_data;
    logic        cpu_tx_done;
    logic [63:0] mac_tx_data;
    logic        mac_tx_valid;
    logic        mac_tx_eof;
    logic        mac_tx_ready;
    logic [15:0] cpu_frames_sent;

    always #5 mac_clk = ~mac_clk;

    tge_tx_arbiter #(.IFG_CYCLES(2)) dut (
        .mac_clk               (mac_clk),
        .mac_rst               (mac_rst),
        .app_data              (app_data),
        .app_valid             (app_valid),
        .app_eof               (app_eof),
        .app_ready             (app_ready),
        .cpu_tx_ready          (cpu_tx_ready),
        .cpu_tx_size           (cpu_tx_size),
        .cpu_tx_buffer_addr    (cpu_tx_buffer_addr),
        .cpu_tx_buffer_rd_data (cpu_tx_buffer_rd_data),
        .cpu_tx_done           (cpu_tx_done),
        .mac_tx_data           (mac_tx_data),
        .mac_tx_valid          (mac_tx_valid),
        .mac_tx_eof            (mac_tx_eof),
        .mac_tx_ready          (mac_tx_ready),
        .cpu_frames_sent       (cpu_frames_sent)
    );

    logic [63:0] mem [256];

    always @(posedge mac_clk)
        cpu_tx_buffer_rd_data <= mem[cpu_tx_buffer_addr];

    logic [63:0] words [$];
    int          vld_cnt = 0;
    int          done_cnt = 0;
    logic        app_acc = 1'b0;

    always @(negedge mac_clk) begin
        app_acc <= app_valid && app_ready;
        if (mac_tx_valid && mac_tx_ready) words.push_back(mac_tx_data);
        if (mac_tx_valid) vld_cnt <= vld_cnt + 1;
        if (cpu_tx_done) done_cnt <= done_cnt + 1;
    end

    int errs = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    int app_idx = 0;
    int app_total = 0;
    int app_flen = 1;
    int app_base = 0;

    function automatic logic [63:0] app_word(input int i);
        return 64'hA5A5_0000_0000_0000 + 64'(i);
    endfunction

    task automatic drive_app();
        if (app_idx >= app_total) begin
            app_valid = 1'b0;
            app_eof   = 1'b0;
            app_data  = '0;
        end else begin
            app_valid = 1'b1;
            app_data  = app_word(app_base + app_idx);
            app_eof   = ((app_idx % app_flen) == app_flen - 1);
        end
    endtask

    task automatic start_app(input int total, input int flen, input int base);
        app_idx   = 0;
        app_total = total;
        app_flen  = flen;
        app_base  = base;
        drive_app();
    endtask

    task automatic tick();
        @(posedge mac_clk);
        #1;
        if (app_acc) begin
            app_idx++;
            drive_app();
        end
        #1;
    endtask

    task automatic wait_done(input string tag, input int maxc);
        int start;
        int n;
        start = done_cnt;
        n = 0;
        while (done_cnt == start && n < maxc) begin
            tick();
            n++;
        end
        chk(tag, 64'(done_cnt != start), 64'd1);
    endtask

    task automatic wait_words(input string tag, input int target,
                              input int maxc);
        int n;
        n = 0;
        while (words.size() < target && n < maxc) begin
            tick();
            n++;
        end
        chk(tag, 64'(words.size() >= target), 64'd1);
    endtask

    initial begin
        #400000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    int          wbase;
    int          v0;
    int          d0;
    logic [9:0]  vexp;
    logic [9:0]  dexp;

    initial begin
        for (int i = 0; i < 256; i++)
            mem[i] = 64'hC0DE_0000_0000_0000 | 64'(i);
        mac_rst      = 1'b1;
        mac_tx_ready = 1'b1;
        cpu_tx_ready = 1'b0;
        cpu_tx_size  = 8'd0;
        start_app(0, 1, 0);
        repeat (2) tick();

        chk("rst_valid", 64'(mac_tx_valid), 64'd0);
        chk("rst_data", mac_tx_data, 64'd0);
        chk("rst_eof", 64'(mac_tx_eof), 64'd0);
        chk("rst_app_ready", 64'(app_ready), 64'd0);
        chk("rst_addr", 64'(cpu_tx_buffer_addr), 64'd0);
        chk("rst_done", 64'(cpu_tx_done), 64'd0);
        chk("rst_frames", 64'(cpu_frames_sent), 64'd0);

        // CPU frame of 3 words at one word per two cycles
        mac_rst      = 1'b0;
        cpu_tx_size  = 8'd3;
        cpu_tx_ready = 1'b1;
        #1;
        vexp = 10'b0001010100;
        dexp = 10'b0010000000;
        for (int i = 0; i < 10; i++) begin
            chk("cpu3_valid", 64'(mac_tx_valid), 64'(vexp[i]));
            chk("cpu3_done", 64'(cpu_tx_done), 64'(dexp[i]));
            if (vexp[i]) begin
                chk("cpu3_data", mac_tx_data, mem[i/2-1]);
                chk("cpu3_eof", 64'(mac_tx_eof), 64'(i == 6));
            end
            tick();
        end
        chk("cpu3_frames", 64'(cpu_frames_sent), 64'd1);

        // held-high ready must not retrigger
        v0 = vld_cnt;
        d0 = done_cnt;
        repeat (20) tick();
        chk("hold_valid", 64'(vld_cnt - v0), 64'd0);
        chk("hold_done", 64'(done_cnt - d0), 64'd0);

        cpu_tx_ready = 1'b0;
        tick();
        cpu_tx_ready = 1'b1;
        wbase = words.size();
        wait_done("rearm_done", 40);
        chk("rearm_words", 64'(words.size() - wbase), 64'd3);
        chk("rearm_frames", 64'(cpu_frames_sent), 64'd2);

        // zero-size frame
        cpu_tx_ready = 1'b0;
        repeat (4) tick();
        cpu_tx_size  = 8'd0;
        cpu_tx_ready = 1'b1;
        v0 = vld_cnt;
        d0 = done_cnt;
        tick();
        chk("zero_done_pulse", 64'(cpu_tx_done), 64'd1);
        chk("zero_valid", 64'(mac_tx_valid), 64'd0);
        tick();
        chk("zero_done_end", 64'(cpu_tx_done), 64'd0);
        repeat (5) tick();
        chk("zero_no_valid", 64'(vld_cnt - v0), 64'd0);
        chk("zero_one_done", 64'(done_cnt - d0), 64'd1);
        chk("zero_frames", 64'(cpu_frames_sent), 64'd2);

        // stall on word 2 for 5 cycles; size change after grant ignored
        cpu_tx_ready = 1'b0;
        cpu_tx_size  = 8'd3;
        repeat (2) tick();
        cpu_tx_ready = 1'b1;
        wbase = words.size();
        tick();
        tick();
        cpu_tx_size = 8'd7;
        tick();
        tick();
        mac_tx_ready = 1'b0;
        #1;
        for (int k = 0; k < 5; k++) begin
            chk("stall_valid", 64'(mac_tx_valid), 64'd1);
            chk("stall_data", mac_tx_data, mem[1]);
            chk("stall_addr", 64'(cpu_tx_buffer_addr), 64'd1);
            tick();
        end
        mac_tx_ready = 1'b1;
        wait_done("stall_done", 40);
        chk("stall_words", 64'(words.size() - wbase), 64'd3);
        for (int k = 0; k < 3; k++)
            chk("stall_seq", words[wbase+k], mem[k]);
        chk("stall_frames", 64'(cpu_frames_sent), 64'd3);

        // both pending after reset: app wins, gap, then CPU
        mac_rst      = 1'b1;
        cpu_tx_size  = 8'd2;
        cpu_tx_ready = 1'b1;
        start_app(2, 2, 0);
        tick();
        tick();
        mac_rst = 1'b0;
        #1;
        chk("both_c0_ready", 64'(app_ready), 64'd0);
        chk("both_c0_valid", 64'(mac_tx_valid), 64'd0);
        tick();
        chk("both_c1_valid", 64'(mac_tx_valid), 64'd1);
        chk("both_c1_data", mac_tx_data, app_word(0));
        chk("both_c1_ready", 64'(app_ready), 64'd1);
        chk("both_c1_eof", 64'(mac_tx_eof), 64'd0);
        tick();
        chk("both_c2_data", mac_tx_data, app_word(1));
        chk("both_c2_eof", 64'(mac_tx_eof), 64'd1);
        tick();
        chk("gap1_valid", 64'(mac_tx_valid), 64'd0);
        chk("gap1_ready", 64'(app_ready), 64'd0);
        tick();
        chk("gap2_valid", 64'(mac_tx_valid), 64'd0);
        wbase = words.size();
        wait_done("both_cpu_done", 40);
        chk("both_cpu_words", 64'(words.size() - wbase), 64'd2);
        chk("both_cpu_w0", words[wbase], mem[0]);
        chk("both_cpu_w1", words[wbase+1], mem[1]);
        chk("both_frames", 64'(cpu_frames_sent), 64'd1);

        // round robin: app, CPU, app with both pending throughout
        cpu_tx_ready = 1'b0;
        repeat (4) tick();
        wbase = words.size();
        start_app(2, 1, 10);
        cpu_tx_ready = 1'b1;
        wait_words("rr_wait", wbase + 4, 80);
        chk("rr_first_app", words[wbase], app_word(10));
        chk("rr_cpu_w0", words[wbase+1], mem[0]);
        chk("rr_cpu_w1", words[wbase+2], mem[1]);
        chk("rr_second_app", words[wbase+3], app_word(11));

        // reset in the middle of a CPU frame
        cpu_tx_ready = 1'b0;
        cpu_tx_size  = 8'd3;
        repeat (4) tick();
        cpu_tx_ready = 1'b1;
        repeat (4) tick();
        chk("mid_pre_valid", 64'(mac_tx_valid), 64'd1);
        d0 = done_cnt;
        mac_rst = 1'b1;
        #1;
        chk("mid_valid", 64'(mac_tx_valid), 64'd0);
        chk("mid_data", mac_tx_data, 64'd0);
        chk("mid_eof", 64'(mac_tx_eof), 64'd0);
        chk("mid_addr", 64'(cpu_tx_buffer_addr), 64'd0);
        chk("mid_done", 64'(cpu_tx_done), 64'd0);
        chk("mid_frames", 64'(cpu_frames_sent), 64'd0);
        tick();
        tick();
        mac_rst = 1'b0;
        wbase = words.size();
        wait_done("mid_restart_done", 40);
        chk("mid_words", 64'(words.size() - wbase), 64'd3);
        for (int k = 0; k < 3; k++)
            chk("mid_seq", words[wbase+k], mem[k]);
        chk("mid_one_done", 64'(done_cnt - d0), 64'd1);
        chk("mid_frames_after", 64'(cpu_frames_sent), 64'd1);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/tge_tx_arbiter.md
TGE_TX_ARBITER -- requirements
Module: tge_tx_arbiter

Interface
REQ-001 Parameter IFG_CYCLES, default 2: minimum idle cycles on the MAC side after each frame's last word is accepted (0 = no gap).
REQ-002 mac_clk  in  1  sole clock; all ports synchronous to it.
REQ-003 Reset is asynchronous and active-high: mac_rst  in  1.
REQ-004 app_data  in  64  application frame word.
REQ-005 app_valid  in  1  app_data valid.
REQ-006 app_eof  in  1  last word of the application frame.
REQ-007 app_ready  out  1  application word accepted when app_valid && app_ready.
REQ-008 cpu_tx_ready  in  1  CPU frame pending in the TX buffer.
REQ-009 cpu_tx_size  in  8  CPU frame length in 64-bit words; sampled at grant.
REQ-010 cpu_tx_buffer_addr  out  8  TX buffer read address.
REQ-011 cpu_tx_buffer_rd_data  in  64  TX buffer read data, valid one cycle after the address.
REQ-012 cpu_tx_done  out  1  one-cycle pulse when the CPU frame is finished.
REQ-013 mac_tx_data  out  64, mac_tx_valid  out  1, mac_tx_eof  out  1  MAC transmit word, valid, last-word flag.
REQ-014 mac_tx_ready  in  1  MAC accepts the word when mac_tx_valid && mac_tx_ready.
REQ-015 cpu_frames_sent  out  16  count of completed CPU frames, wraps 0xFFFF->0.

Function
REQ-016 States SHALL be IDLE, APP, CPU_READ, CPU_SEND, GAP.
REQ-017 A source is pending when: app = app_valid; cpu = cpu_tx_ready && armed.
REQ-018 IDLE: if exactly one source is pending, grant it; if both are pending, grant the source not granted last (round-robin flag last_cpu); if neither is pending, stay in IDLE.
REQ-019 The grant SHALL only change in IDLE; a frame in progress is never preempted.
REQ-020 APP: mac_tx_data=app_data, mac_tx_valid=app_valid, mac_tx_eof=app_eof, app_ready=mac_tx_ready (combinational pass-through); on an accepted word with app_eof=1, go to GAP (IDLE if IFG_CYCLES=0); last_cpu<=0.
REQ-021 app_ready SHALL be 0 in every state except APP.
REQ-022 CPU grant with cpu_tx_size=0: no MAC output; pulse cpu_tx_done on the next cycle; armed<=0; last_cpu<=1; stay in IDLE; cpu_frames_sent unchanged.
REQ-023 CPU grant with size N>0: latch N; cpu_tx_buffer_addr<=0; go to CPU_READ.
REQ-024 CPU_READ lasts one cycle with the address stable and mac_tx_valid=0, then goes to CPU_SEND.
REQ-025 CPU_SEND: mac_tx_valid=1; mac_tx_data=cpu_tx_buffer_rd_data; address held; mac_tx_eof=1 iff addr==N-1.
REQ-026 In CPU_SEND, an accepted non-last word sets addr+1 and returns to CPU_READ; peak rate is 1 word per 2 cycles.
REQ-027 An accepted last word sets addr<=0, pulses cpu_tx_done on the next cycle, increments cpu_frames_sent, sets armed<=0 and last_cpu<=1, and goes to GAP or IDLE as in REQ-020.
REQ-028 armed SHALL re-set to 1 on any cycle where cpu_tx_ready=0; a held-high cpu_tx_ready after done never retriggers.
REQ-029 GAP: mac_tx_valid=0; count IFG_CYCLES cycles, then go to IDLE; arbitration resumes in IDLE.
REQ-030 Outside APP and CPU_SEND: mac_tx_valid=0, mac_tx_eof=0, mac_tx_data=0.
REQ-031 Changes to cpu_tx_size after grant SHALL be ignored until the next grant.

Reset
REQ-032 mac_rst asserted SHALL immediately force IDLE with mac_tx_valid=0, mac_tx_eof=0, mac_tx_data=0, app_ready=0, cpu_tx_buffer_addr=0, cpu_tx_done=0, cpu_frames_sent=0, armed=1, last_cpu=1, and the gap counter=0.
REQ-033 Reset mid-frame SHALL truncate the frame with no eof and no cpu_tx_done; after release, a still-high cpu_tx_ready re-sends the CPU frame from addr 0.
REQ-034 With both sources pending in the first IDLE cycle after reset, APP SHALL win.

Verification
REQ-035 CPU only, size=3, buffer words A,B,C, mac_tx_ready=1 -> valid words A,B,C on alternate cycles, eof on C, done pulse 1 cycle later, cpu_frames_sent=1.
REQ-036 Both pending after reset, IFG_CYCLES=2 -> app frame first, 2 idle cycles, then CPU frame; with both pending again, app wins.
REQ-037 mac_tx_ready=0 for 5 cycles during CPU word 2 -> word 2 and address held stable, then resumes; no word lost or duplicated.
REQ-038 cpu_tx_ready held high for 20 cycles after done -> exactly one frame; drop for 1 cycle and raise again -> second frame.
REQ-039 size=0 -> done pulse with no mac_tx_valid; counter unchanged.
REQ-040 mac_rst asserted mid CPU frame -> outputs zero in the same cycle; after release, frame restarts at addr 0; cpu_frames_sent=0.
